// File: rtl/mem_lock_arbiter.sv
// mem_lock_arbiter: round-robin arbiter for C cores sharing one main memory and a lock table.
module mem_lock_arbiter #(
  parameter int C = 2,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 10,
  parameter int LOCKS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [C-1:0]    main_mem_read,
  input  logic [C-1:0]    main_mem_write,
  input  logic [C*AW-1:0] main_mem_read_adr,
  input  logic [C*AW-1:0] main_mem_write_adr,
  input  logic [C*DW-1:0] main_mem_write_dat,
  output logic [C-1:0]    main_mem_ac,
  output logic [AW-1:0]   mem_adr,
  output logic [DW-1:0]   mem_wdat,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [C*LW-1:0] lock_adr,
  input  logic [C-1:0]    lock_en,
  input  logic [C-1:0]    unlock_en,
  output logic [C-1:0]    lock_ac,
  output logic            unlock_err,
  output logic [4:0]      locks_held
);
  localparam int CW = $clog2(C);
  function automatic logic [CW:0] rr_pick(input logic [C-1:0] req, input logic [CW-1:0] ptr);
    logic [CW:0] r;
    int j;
    r = '0;
    for (int k = C - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % C;
      if (req[j]) r = {1'b1, CW'(j)};
    end
    return r;
  endfunction
  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] p);
    return CW'((int'(p) + 1) % C);
  endfunction
  logic [CW-1:0] mptr, lptr, mi, li;
  logic mg, lg, free_any, uhit;
  logic [C-1:0] lelig, own_hit, any_hit;
  logic [LOCKS-1:0] valid;
  logic [LW-1:0] tadr [LOCKS];
  logic [CW-1:0] town [LOCKS];
  logic [LW-1:0] wa;
  int free_idx, uidx;
  assign {mg, mi} = rr_pick(main_mem_read | main_mem_write, mptr);
  always_comb begin
    any_hit = '0;
    own_hit = '0;
    free_any = 1'b0;
    free_idx = 0;
    for (int e = LOCKS - 1; e >= 0; e--) begin
      if (!valid[e]) begin
        free_any = 1'b1;
        free_idx = e;
      end
    end
    for (int i = 0; i < C; i++)
      for (int e = 0; e < LOCKS; e++)
        if (valid[e] && tadr[e] == lock_adr[i*LW +: LW]) begin
          any_hit[i] = 1'b1;
          if (town[e] == CW'(i)) own_hit[i] = 1'b1;
        end
  end
  // refused locks (held elsewhere or table full) never take the slot
  assign lelig = unlock_en | (lock_en & (own_hit | (~any_hit & {C{free_any}})));
  assign {lg, li} = rr_pick(lelig, lptr);
  assign wa = lock_adr[li*LW +: LW];
  always_comb begin
    uhit = 1'b0;
    uidx = 0;
    for (int e = 0; e < LOCKS; e++)
      if (valid[e] && tadr[e] == wa && town[e] == li) begin
        uhit = 1'b1;
        uidx = e;
      end
  end
  always_comb begin
    locks_held = '0;
    for (int e = 0; e < LOCKS; e++) locks_held = locks_held + 5'(valid[e]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_mem_ac <= '0;
      mem_adr <= '0;
      mem_wdat <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      mptr <= '0;
    end else begin
      main_mem_ac <= mg ? C'(1) << mi : '0;
      mem_we <= mg & main_mem_write[mi];
      mem_re <= mg & ~main_mem_write[mi];
      if (mg) begin
        mptr <= nxt(mi);
        mem_adr <= main_mem_write[mi] ? main_mem_write_adr[mi*AW +: AW] : main_mem_read_adr[mi*AW +: AW];
        if (main_mem_write[mi]) mem_wdat <= main_mem_write_dat[mi*DW +: DW];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_ac <= '0;
      unlock_err <= 1'b0;
      lptr <= '0;
      valid <= '0;
    end else begin
      lock_ac <= lg ? C'(1) << li : '0;
      unlock_err <= lg & unlock_en[li] & ~uhit;
      if (lg) begin
        lptr <= nxt(li);
        if (unlock_en[li]) begin
          if (uhit) valid[uidx] <= 1'b0;
        end else if (!own_hit[li]) begin
          valid[free_idx] <= 1'b1;
          tadr[free_idx] <= wa;
          town[free_idx] <= li;
        end
      end
    end
  end
endmodule
